// File: rtl/audio_mux_mc.sv
// ---------------------------------------------------------------------------
// audio_mux_mc
//   Multi-channel audio read mux with a trigger generator for the synth.
//   The host (HPS/JACK reader) reads NUM_CH sound FIFO outputs through a
//   32-bit Avalon-MM-style slave. The synth trigger comes either from the
//   synchronised I2S lrck (buffersize 0) or from a FILL burst of exactly
//   `buffersize` triggers after each JACK read cycle.
//
//   Optional feature macro: AUDIO_MUX_IRQ_EN adds the irq output. irq is set
//   on DONE entry or on an overrun, and cleared by writing 1 to STATUS bit2.
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   address[3:0]    register word address
//   read, write     slave strobes
//   datain[31:0]    write data
//   dataout[31:0]   registered read data (1-cycle latency, holds when idle)
//   sound_fifo      NUM_CH samples, channel c at [c*AUD_BIT_DEPTH +: AUD_BIT_DEPTH]
//   ch_read         per-channel FIFO pop (combinational)
//   xxxx_top        synth voice-loop top strobe
//   lrck            asynchronous I2S word clock
//   run             synth busy, blocks triggers
//   trig            sample trigger to the synth
//   i2s_enable      high while the active buffersize is 0
//   sample_ready    high when not filling
//   irq             interrupt (AUDIO_MUX_IRQ_EN only)
//
// Register map: 0..NUM_CH-1 samples, 8 CTRL, 9 BUFSIZE, 10 STATUS, 11 COUNT.
// ---------------------------------------------------------------------------
module audio_mux_mc #(
   parameter int NUM_CH        = 2,
   parameter int AUD_BIT_DEPTH = 24,
   parameter int FIFO_WIDTH    = 6,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [3:0]                        address,
   input  logic                              read,
   input  logic                              write,
   input  logic [31:0]                       datain,
   input  logic [NUM_CH*AUD_BIT_DEPTH-1:0]   sound_fifo,
   input  logic                              xxxx_top,
   input  logic                              lrck,
   input  logic                              run,
   output logic [31:0]                       dataout,
   output logic [NUM_CH-1:0]                 ch_read,
   output logic                              trig,
   output logic                              i2s_enable,
   output logic                              sample_ready
`ifdef AUDIO_MUX_IRQ_EN
   ,output logic                             irq
`endif
);

   localparam int BW = FIFO_WIDTH + 1;

   localparam logic [3:0] ADDR_CTRL    = 4'd8;
   localparam logic [3:0] ADDR_BUFSIZE = 4'd9;
   localparam logic [3:0] ADDR_STATUS  = 4'd10;
   localparam logic [3:0] ADDR_COUNT   = 4'd11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [BW-1:0]       counter_q, counter_d;
   logic [BW-1:0]       act_bs_q, act_bs_d;
   logic [BW-1:0]       pend_bs_q, pend_bs_d;
   logic                jack_act_q, jack_act_d;
   logic                act_dly_q, act_dly_d;
   logic                run_trig_q, run_trig_d;
   logic                overrun_q, overrun_d;
   logic                underrun_q, underrun_d;
   logic [15:0]         cycle_count_q, cycle_count_d;
   logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
   logic [31:0]         dataout_q, dataout_d;

   logic                wr_ctrl, wr_bufsize, wr_status;
   logic                soft_restart, cyc_end;
   logic                overrun_set, underrun_set;
   logic [BW-1:0]       counter_inc;
   logic [BW-1:0]       wr_bs_val;
   logic                irq_bit;
   logic [31:0]         ch_word [NUM_CH];
   logic                unused_ok;

   // Only the low bits of datain carry register fields.
   assign unused_ok = &{1'b0, datain};

   assign wr_ctrl      = write && (address == ADDR_CTRL);
   assign wr_bufsize   = write && (address == ADDR_BUFSIZE);
   assign wr_status    = write && (address == ADDR_STATUS);
   assign soft_restart = wr_ctrl && datain[1];
   assign wr_bs_val    = datain[BW-1:0];
   assign counter_inc  = counter_q + BW'(1);

   // End of a JACK read cycle: registered falling edge of jack_read_act.
   assign cyc_end = act_dly_q && !jack_act_q;

   // Per-channel sample words, left-justified with zero padding below.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign ch_read[gi] = read && (address == 4'(gi));
         assign ch_word[gi] = 32'(sound_fifo[gi*AUD_BIT_DEPTH +: AUD_BIT_DEPTH])
                              << (32 - AUD_BIT_DEPTH);
      end
   endgenerate

   // A host pop while the buffer being filled is still empty.
   assign underrun_set = (|ch_read) && (state_q == ST_FILL) && (counter_q == '0);

   // ------------------------------------------------------------------
   // FSM next state, counters and buffersize shadowing
   // ------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      counter_d     = counter_q;
      act_bs_d      = act_bs_q;
      cycle_count_d = cycle_count_q;
      run_trig_d    = 1'b0;
      overrun_set   = 1'b0;
      pend_bs_d     = wr_bufsize ? wr_bs_val : pend_bs_q;
      jack_act_d    = wr_ctrl ? datain[0] : jack_act_q;
      act_dly_d     = jack_act_q;
      lrck_sync_d   = {lrck_sync_q[SYNC_STAGES-2:0], lrck};

      case (state_q)
         ST_IDLE: begin
            if (cyc_end && (pend_bs_q != '0)) begin
               state_d       = ST_FILL;
               act_bs_d      = pend_bs_q;
               counter_d     = '0;
               cycle_count_d = cycle_count_q + 16'd1;
            end else if (wr_bufsize && ((act_bs_q == '0) || (wr_bs_val == '0))) begin
               // Mode changes to/from I2S take effect without a JACK cycle.
               act_bs_d = wr_bs_val;
            end
         end
         ST_FILL: begin
            if (cyc_end) begin
               // New JACK cycle before the burst finished: restart it.
               overrun_set   = 1'b1;
               counter_d     = '0;
               act_bs_d      = pend_bs_q;
               cycle_count_d = cycle_count_q + 16'd1;
               if (pend_bs_q == '0) begin
                  state_d = ST_IDLE;
               end
            end else begin
               if (run_trig_q) begin
                  counter_d = counter_inc;
                  if (counter_inc == act_bs_q) begin
                     state_d = ST_DONE;
                  end
               end
               // Suppress a strobe that coincides with the final count.
               if (xxxx_top && !run && !(run_trig_q && (counter_inc == act_bs_q))) begin
                  run_trig_d = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d  = ST_IDLE;
            act_bs_d = pend_bs_q;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (soft_restart) begin
         state_d       = ST_IDLE;
         counter_d     = '0;
         run_trig_d    = 1'b0;
         overrun_set   = 1'b0;
         act_bs_d      = act_bs_q;
         cycle_count_d = cycle_count_q;
      end
   end

   // Sticky status flags: a set event beats a simultaneous clear.
   always_comb begin
      overrun_d  = (overrun_q  && !(wr_status && datain[0])) || overrun_set;
      underrun_d = (underrun_q && !(wr_status && datain[1])) || underrun_set;
   end

`ifdef AUDIO_MUX_IRQ_EN
   logic irq_q, irq_d;
   logic done_entry;

   assign done_entry = (state_q == ST_FILL) && (state_d == ST_DONE);

   always_comb begin
      irq_d = (irq_q && !(wr_status && datain[2])) || done_entry || overrun_set;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign irq     = irq_q;
   assign irq_bit = irq_q;
`else
   assign irq_bit = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Read data mux (registered, holds while read is low)
   // ------------------------------------------------------------------
   always_comb begin
      dataout_d = dataout_q;
      if (read) begin
         dataout_d = 32'd0;
         for (int c = 0; c < NUM_CH; c++) begin
            if (address == 4'(c)) begin
               dataout_d = ch_word[c];
            end
         end
         case (address)
            ADDR_CTRL:    dataout_d = {31'd0, jack_act_q};
            ADDR_BUFSIZE: dataout_d = 32'(pend_bs_q);
            ADDR_STATUS:  dataout_d = {cycle_count_q, 6'd0, state_q, 5'd0,
                                       irq_bit, underrun_q, overrun_q};
            ADDR_COUNT:   dataout_d = 32'(counter_q);
            default:      ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         counter_q     <= '0;
         act_bs_q      <= '0;
         pend_bs_q     <= '0;
         jack_act_q    <= 1'b0;
         act_dly_q     <= 1'b0;
         run_trig_q    <= 1'b0;
         overrun_q     <= 1'b0;
         underrun_q    <= 1'b0;
         cycle_count_q <= 16'd0;
         lrck_sync_q   <= '0;
         dataout_q     <= 32'd0;
      end else begin
         state_q       <= state_d;
         counter_q     <= counter_d;
         act_bs_q      <= act_bs_d;
         pend_bs_q     <= pend_bs_d;
         jack_act_q    <= jack_act_d;
         act_dly_q     <= act_dly_d;
         run_trig_q    <= run_trig_d;
         overrun_q     <= overrun_d;
         underrun_q    <= underrun_d;
         cycle_count_q <= cycle_count_d;
         lrck_sync_q   <= lrck_sync_d;
         dataout_q     <= dataout_d;
      end
   end

   // trig is built only from flops so an asynchronous reset clears it at once.
   assign trig         = (act_bs_q == '0) ? lrck_sync_q[SYNC_STAGES-1] : run_trig_q;
   assign i2s_enable   = (act_bs_q == '0);
   assign sample_ready = (state_q != ST_FILL);
   assign dataout      = dataout_q;

endmodule

// File: tb/tb_audio_mux_mc.sv
module tb_audio_mux_mc;

   localparam int NUM_CH = 4;
   localparam int AUD    = 24;
   localparam int FW     = 6;
   localparam int SYNC   = 2;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic [3:0]              address = 4'd0;
   logic                    read = 1'b0;
   logic                    write = 1'b0;
   logic [31:0]             datain = 32'd0;
   logic [NUM_CH*AUD-1:0]   sound_fifo = '0;
   logic                    xxxx_top = 1'b0;
   logic                    lrck = 1'b0;
   logic                    run = 1'b0;
   logic [31:0]             dataout;
   logic [NUM_CH-1:0]       ch_read;
   logic                    trig;
   logic                    i2s_enable;
   logic                    sample_ready;
`ifdef AUDIO_MUX_IRQ_EN
   logic                    irq;
`endif

   int errors = 0;
   int checks = 0;

   audio_mux_mc #(
      .NUM_CH(NUM_CH), .AUD_BIT_DEPTH(AUD), .FIFO_WIDTH(FW), .SYNC_STAGES(SYNC)
   ) dut (
      .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
      .datain(datain), .sound_fifo(sound_fifo), .xxxx_top(xxxx_top), .lrck(lrck),
      .run(run), .dataout(dataout), .ch_read(ch_read), .trig(trig),
      .i2s_enable(i2s_enable), .sample_ready(sample_ready)
`ifdef AUDIO_MUX_IRQ_EN
      , .irq(irq)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      address = a; datain = d; write = 1'b1;
      tick();
      write = 1'b0;
      $display("write addr=%0d data=%h", a, d);
   endtask

   task automatic rd(input logic [3:0] a);
      address = a; read = 1'b1;
      tick();
      read = 1'b0;
      $display("read  addr=%0d data=%h", a, dataout);
   endtask

   // CTRL bit0 1->0 then one more clock: FILL is entered on that edge.
   task automatic start_cycle();
      wr(4'd8, 32'd1);
      wr(4'd8, 32'd0);
      tick();
   endtask

   // One xxxx_top strobe; trig must follow one clock later for one clock.
   task automatic strobe(input logic r, input logic exp_trig);
      xxxx_top = 1'b1; run = r;
      tick();
      xxxx_top = 1'b0; run = 1'b0;
      checks++;
      if (trig !== exp_trig) begin
         errors++; $display("FAIL strobe_trig: got %b expected %b", trig, exp_trig);
      end else $display("strobe run=%b trig=%b", r, trig);
      tick();
      checks++;
      if (trig !== 1'b0) begin
         errors++; $display("FAIL strobe_trig_width: got %b expected 0", trig);
      end
      tick();
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      checks++;
      if (dataout !== 32'd0) begin errors++; $display("FAIL reset_dataout: got %h expected 0", dataout); end
      checks++;
      if ({trig, i2s_enable, sample_ready} !== 3'b011) begin
         errors++; $display("FAIL reset_outputs: got %b expected 011", {trig, i2s_enable, sample_ready});
      end
      @(posedge clk); #1 reset = 1'b0;
      tick();
      checks++;
      if (ch_read !== 4'b0000) begin errors++; $display("FAIL reset_ch_read: got %b expected 0000", ch_read); end
      $display("reset done");
   endtask

   task automatic test_i2s();
      lrck = 1'b1;
      tick();
      checks++;
      if (trig !== 1'b0) begin errors++; $display("FAIL i2s_delay1: got %b expected 0", trig); end
      tick();
      checks++;
      if (trig !== 1'b1) begin errors++; $display("FAIL i2s_rise: got %b expected 1", trig); end
      lrck = 1'b0;
      tick();
      checks++;
      if (trig !== 1'b1) begin errors++; $display("FAIL i2s_hold: got %b expected 1", trig); end
      tick();
      checks++;
      if ({trig, i2s_enable, ch_read} !== 6'b010000) begin
         errors++; $display("FAIL i2s_fall: got %b expected 010000", {trig, i2s_enable, ch_read});
      end
      $display("i2s trig follows lrck");
   endtask

   task automatic test_read();
      sound_fifo = {24'h0F0F0F, 24'hABCDEF, 24'h654321, 24'h123456};
      address = 4'd2; read = 1'b1;
      #1;
      checks++;
      if (ch_read !== 4'b0100) begin errors++; $display("FAIL ch_read_strobe: got %b expected 0100", ch_read); end
      tick();
      read = 1'b0;
      #1;
      checks++;
      if (ch_read !== 4'b0000) begin errors++; $display("FAIL ch_read_release: got %b expected 0000", ch_read); end
      checks++;
      if (dataout !== 32'hABCDEF00) begin errors++; $display("FAIL read_ch2: got %h expected ABCDEF00", dataout); end
      tick();
      checks++;
      if (dataout !== 32'hABCDEF00) begin errors++; $display("FAIL read_hold: got %h expected ABCDEF00", dataout); end
      rd(4'd3);
      checks++;
      if (dataout !== 32'h0F0F0F00) begin errors++; $display("FAIL read_ch3: got %h expected 0F0F0F00", dataout); end
      rd(4'd12);
      checks++;
      if (dataout !== 32'd0) begin errors++; $display("FAIL read_unmapped: got %h expected 0", dataout); end
   endtask

   task automatic test_jack_burst();
      logic [7:0] exp;
      exp = 8'b00011111;  // strobe k (bit k) triggers
      wr(4'd9, 32'd5);
      checks++;
      if (i2s_enable !== 1'b0) begin errors++; $display("FAIL bufsize_mode: got %b expected 0", i2s_enable); end
      rd(4'd9);
      checks++;
      if (dataout !== 32'd5) begin errors++; $display("FAIL bufsize_read: got %h expected 5", dataout); end
      start_cycle();
      checks++;
      if (sample_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b expected 0", sample_ready); end
      for (int k = 0; k < 8; k++) strobe(1'b0, exp[k]);
      checks++;
      if (sample_ready !== 1'b1) begin errors++; $display("FAIL done_ready: got %b expected 1", sample_ready); end
      rd(4'd11);
      checks++;
      if (dataout !== 32'd5) begin errors++; $display("FAIL burst_count: got %h expected 5", dataout); end
      rd(4'd10);
      checks++;
      if ((dataout & ~32'h4) !== 32'h00010000) begin
         errors++; $display("FAIL burst_status: got %h expected 00010000", dataout & ~32'h4);
      end
   endtask

   task automatic test_run_block();
      logic [7:0] exp;
      exp = 8'b00111011;  // strobe 2 blocked by run, later strobes make up
      start_cycle();
      for (int k = 0; k < 8; k++) strobe(k == 2, exp[k]);
      rd(4'd11);
      checks++;
      if (dataout !== 32'd5) begin errors++; $display("FAIL run_count: got %h expected 5", dataout); end
      rd(4'd10);
      checks++;
      if ((dataout & ~32'h4) !== 32'h00020000) begin
         errors++; $display("FAIL run_status: got %h expected 00020000", dataout & ~32'h4);
      end
   endtask

   task automatic test_overrun();
      start_cycle();                 // cycle 3
      strobe(1'b0, 1'b1);
      strobe(1'b0, 1'b1);
      wr(4'd8, 32'd1);
      wr(4'd8, 32'd0);
      wr(4'd10, 32'd1);              // clear lands on the overrun set: set wins
      rd(4'd0);                      // empty buffer pop -> underrun
      rd(4'd10);
      checks++;
      if ((dataout & ~32'h4) !== 32'h00040103) begin
         errors++; $display("FAIL overrun_status: got %h expected 00040103", dataout & ~32'h4);
      end
      rd(4'd11);
      checks++;
      if (dataout !== 32'd0) begin errors++; $display("FAIL overrun_count: got %h expected 0", dataout); end
      for (int k = 0; k < 6; k++) strobe(1'b0, k < 5);
      rd(4'd11);
      checks++;
      if (dataout !== 32'd5) begin errors++; $display("FAIL overrun_refill: got %h expected 5", dataout); end
      wr(4'd10, 32'd3);
      rd(4'd10);
      checks++;
      if ((dataout & ~32'h4) !== 32'h00040000) begin
         errors++; $display("FAIL status_clear: got %h expected 00040000", dataout & ~32'h4);
      end
   endtask

   task automatic test_soft_restart();
      start_cycle();                 // cycle 5
      strobe(1'b0, 1'b1);
      wr(4'd8, 32'd2);
      checks++;
      if (sample_ready !== 1'b1) begin errors++; $display("FAIL restart_ready: got %b expected 1", sample_ready); end
      rd(4'd11);
      checks++;
      if (dataout !== 32'd0) begin errors++; $display("FAIL restart_count: got %h expected 0", dataout); end
      rd(4'd10);
      checks++;
      if ((dataout & ~32'h4) !== 32'h00050000) begin
         errors++; $display("FAIL restart_status: got %h expected 00050000", dataout & ~32'h4);
      end
   endtask

   task automatic test_i2s_return();
      wr(4'd9, 32'd0);
      checks++;
      if (i2s_enable !== 1'b1) begin errors++; $display("FAIL i2s_return_mode: got %b expected 1", i2s_enable); end
      lrck = 1'b1;
      tick(); tick();
      checks++;
      if (trig !== 1'b1) begin errors++; $display("FAIL i2s_return_trig: got %b expected 1", trig); end
      lrck = 1'b0;
      tick(); tick();
      $display("i2s mode restored");
   endtask

   task automatic test_async_reset();
      wr(4'd9, 32'd3);
      start_cycle();
`ifdef AUDIO_MUX_IRQ_EN
      for (int k = 0; k < 3; k++) strobe(1'b0, 1'b1);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_done: got %b expected 1", irq); end
      wr(4'd10, 32'd4);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
      start_cycle();
      start_cycle();                 // second cycle end while filling -> overrun
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_overrun: got %b expected 1", irq); end
`endif
      xxxx_top = 1'b1;
      tick();
      xxxx_top = 1'b0;
      checks++;
      if (trig !== 1'b1) begin errors++; $display("FAIL pre_reset_trig: got %b expected 1", trig); end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({trig, sample_ready, i2s_enable} !== 3'b011) begin
         errors++; $display("FAIL async_reset: got %b expected 011", {trig, sample_ready, i2s_enable});
      end
`ifdef AUDIO_MUX_IRQ_EN
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL async_reset_irq: got %b expected 0", irq); end
`endif
      @(posedge clk); #1 reset = 1'b0;
      rd(4'd10);
      checks++;
      if (dataout !== 32'd0) begin errors++; $display("FAIL post_reset_status: got %h expected 0", dataout); end
   endtask

   initial begin
      test_reset();
      test_i2s();
      test_read();
      test_jack_burst();
      test_run_block();
      test_overrun();
      test_soft_restart();
      test_i2s_return();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/audio_mux_mc.md
Name: audio_mux_mc

Overview:
- Parametrised multi-channel successor to the stereo audio read mux in the holosynth_audio path.
- Presents NUM_CH sound FIFO outputs on a 32-bit Avalon-MM-style slave for the HPS/JACK reader.
- Generates the per-sample synth trigger in one of two modes:
  - I2S mode: trigger is the synchronised lrck.
  - Buffered/JACK mode: a burst of exactly `buffersize` triggers after each JACK read cycle.
- Adds a FILL/DONE state machine, shadowed buffersize, overrun/underrun status and sample counting.

Parameters:
- NUM_CH, 2: audio channels, 2..8.
- AUD_BIT_DEPTH, 24: sample width, 16..32.
- FIFO_WIDTH, 6: buffersize field is FIFO_WIDTH+1 bits, giving a maximum of 2^(FIFO_WIDTH+1)-1 samples per cycle.
- SYNC_STAGES, 2: lrck synchroniser depth, 2..4.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  4  register word address.
- read  in  1  slave read strobe.
- write  in  1  slave write strobe.
- datain  in  32  write data.
- sound_fifo  in  NUM_CH*AUD_BIT_DEPTH  channel c occupies bits [c*AUD_BIT_DEPTH +: AUD_BIT_DEPTH].
- xxxx_top  in  1  synth voice-loop top strobe (one clk).
- lrck  in  1  asynchronous I2S word clock.
- run  in  1  synth busy; no trigger is issued while high.
- dataout  out  32  read data.
- ch_read  out  NUM_CH  FIFO pop, one bit per channel.
- trig  out  1  sample trigger to the synth.
- i2s_enable  out  1  high in I2S mode.
- sample_ready  out  1  high when not in FILL.
- irq  out  1  present only with AUDIO_MUX_IRQ_EN.

Behaviour:
Register map (word address):
- 0..NUM_CH-1 (R): channel sample, left-justified into dataout[31:32-AUD_BIT_DEPTH]; lower bits 0.
- 8 CTRL (R/W): bit0 jack_read_act. Bit1 (W1) is a soft restart: forces IDLE and counter=0.
- 9 BUFSIZE (R/W): bits[FIFO_WIDTH:0] written to a pending register.
- 10 STATUS (R): bit0 overrun, bit1 underrun, bits[15:8] state, bits[31:16] cycle_count. Write 1 to bit0/bit1 clears that bit.
- 11 COUNT (R): bits[FIFO_WIDTH:0] current fill counter.
- Other addresses read as 0; writes to them are ignored.

Read path:
- ch_read[c] = read && address==c, combinational.
- dataout is registered: 1-cycle latency, holds its value when read is low.

Reset values:
- dataout=0, registers 0.
- State IDLE, counter=0, trig=0, irq=0.
- i2s_enable=1 (buffersize 0), sample_ready=1.

Mode selection:
- Active buffersize (act_bs)=0 selects I2S mode:
  - trig = lrck after SYNC_STAGES flops.
  - i2s_enable=1; state is held in IDLE.
- act_bs≠0 selects JACK mode: i2s_enable=0, trig = run_trig.

JACK cycle end:
- Registered falling edge of jack_read_act (act_dly && !act), 1-cycle pulse (cyc_end).

States:
- IDLE -> FILL on cyc_end. On this transition: act_bs <= pending bufsize, counter <= 0, cycle_count++ (wraps at 16 bits).
- FILL: run_trig <= xxxx_top && !run, registered, so trig rises 1 clk after the qualifying xxxx_top. Each run_trig=1 cycle increments counter.
  - When counter reaches act_bs on the same cycle as the last run_trig -> DONE. No extra trigger is issued.
- DONE -> IDLE the next clk. irq set if enabled.

Boundary conditions:
- cyc_end while in FILL:
  - Set overrun.
  - Restart FILL with counter=0 and a fresh act_bs.
  - run_trig pending that cycle is suppressed.
- ch_read on any channel while state==FILL and counter==0: set underrun (host reading an unfilled buffer).
- BUFSIZE write in any state: only updates the pending register; it never alters an in-progress FILL.
  - In IDLE with act_bs=0 (I2S), pending is copied to act_bs immediately, so a mode change needs no JACK cycle.
- BUFSIZE write of 0: takes effect at the next IDLE entry or immediately in IDLE. A FILL in progress completes first.
- Simultaneous STATUS clear and a set event: the set event wins.
- Asynchronous reset mid-FILL: trig drops to 0 immediately; all state returns to reset values.
- Soft restart aborts FILL without setting any flag.

Optional Feature:
AUDIO_MUX_IRQ_EN
- Defined:
  - irq port exists.
  - irq is set on DONE entry or on an overrun set.
  - Cleared by writing 1 to STATUS bit2. STATUS bit2 reads as the irq level.
- Undefined: no irq port, STATUS bit2 reads 0, no added logic.

Test Plan:
- Reset with buffersize 0, toggle lrck at 48 kHz -> trig follows lrck delayed SYNC_STAGES clks; i2s_enable=1; no ch_read.
- NUM_CH=4; drive channel 2 = 0xABCDEF, read address 2 -> dataout=0xABCDEF00 one clk later; ch_read=4'b0100 for exactly the strobe cycle.
- Write BUFSIZE=5, pulse CTRL bit0 1->0, 8 xxxx_top strobes with run=0 -> exactly 5 trig pulses, each 1 clk after its strobe; COUNT=5; sample_ready=1 after DONE; cycle_count=1.
- Same as above but hold run=1 during the 3rd strobe -> that strobe produces no trig; 5 triggers still complete using later strobes.
- Second CTRL 1->0 after 2 triggers -> overrun=1, COUNT restarts at 0, 5 new triggers follow; a write of 1 to STATUS bit0 clears overrun.
- With AUDIO_MUX_IRQ_EN: irq rises on DONE, clears on a STATUS bit2 write; assert reset mid-FILL -> trig=0 and irq=0 asynchronously.
